// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [6:0] ADDR_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY   = 7'h04;

    localparam int         FRAME_BITS  = 16;
    localparam logic [4:0] CNT_SAT     = 5'd17;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes one asynchronous line into clk and flags its rising/falling edges.
// Latency: STAGES cycles to lvl; rise/fall valid in the same cycle as the new lvl.
// Backpressure: none; free-running.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign lvl  = sync_q[STAGES-1];
    assign rise = lvl & ~prev_q;
    assign fall = ~lvl & prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI (mode 0) slave writing a small register file, with wrap-synchronous PWM duty update.
// Latency: register update and wr_strobe/frame_err SYNC_STAGES+2 cycles after ncs rises.
// Backpressure: none; master must keep ncs high >= SYNC_STAGES+3 cycles between frames.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_copi,
    input  logic       spi_ncs,
    input  logic       pwm_period_wrap,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);

    localparam int            SW         = $clog2(SYNC_STAGES + 2);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SYNC_STAGES + 1);

    state_t        state_q, state_d;
    logic [4:0]    cnt_q;
    logic [15:0]   shreg_q;
    logic [7:0]    pend_val_q;
    logic          pend_flag_q;
    logic          start_pend_q;
    logic          armed_q;
    logic [SW-1:0] settle_q;

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;
    logic unused_edges;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(spi_sclk),
        .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .din(spi_copi),
        .lvl(copi_lvl), .rise(copi_rise), .fall(copi_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .din(spi_ncs),
        .lvl(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );

    assign unused_edges = &{1'b0, sclk_lvl, sclk_fall, copi_rise, copi_fall};

    logic       start;
    logic       frame_w;
    logic [6:0] frame_addr;
    logic [7:0] frame_dat;
    logic       len_ok, addr_ok, in_commit, accept, discard;

    // A fall seen right after reset only reflects the synchronizer filling, so
    // frames start only once ncs has been observed high with settled flops.
    assign start      = armed_q & (ncs_fall | (start_pend_q & ~ncs_lvl));
    assign frame_w    = shreg_q[15];
    assign frame_addr = shreg_q[14:8];
    assign frame_dat  = shreg_q[7:0];
    assign len_ok     = (cnt_q == 5'(FRAME_BITS));
    assign addr_ok    = (int'(frame_addr) < NUM_REGS);
    assign in_commit  = (state_q == COMMIT);
    assign accept     = in_commit & len_ok & frame_w & addr_ok;
    assign discard    = in_commit & (~len_ok | (frame_w & ~addr_ok));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (ncs_rise) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 5'd0;
            shreg_q      <= 16'd0;
            start_pend_q <= 1'b0;
            armed_q      <= 1'b0;
            settle_q     <= '0;
        end else begin
            state_q      <= state_d;
            start_pend_q <= in_commit & ncs_fall;
            if (settle_q != SETTLE_MAX) settle_q <= settle_q + 1'b1;
            if (settle_q == SETTLE_MAX && ncs_lvl) armed_q <= 1'b1;
            if (state_q == IDLE && start) begin
                cnt_q   <= 5'd0;
                shreg_q <= 16'd0;
            end else if (state_q == SHIFT && sclk_rise && !ncs_lvl) begin
                shreg_q <= {shreg_q[14:0], copi_lvl};
                if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 5'd1;
            end
        end
    end

    // Wrap applies the old pending value; a same-cycle commit then re-arms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
            pend_val_q      <= 8'h00;
            pend_flag_q     <= 1'b0;
            wr_strobe       <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            wr_strobe <= accept;
            frame_err <= discard;
            if (pwm_period_wrap && pend_flag_q) begin
                pwm_duty_cycle <= pend_val_q;
                pend_flag_q    <= 1'b0;
            end
            if (accept) begin
                case (frame_addr)
                    ADDR_OUT_LO: en_reg_out_7_0  <= frame_dat;
                    ADDR_OUT_HI: en_reg_out_15_8 <= frame_dat;
                    ADDR_PWM_LO: en_reg_pwm_7_0  <= frame_dat;
                    ADDR_PWM_HI: en_reg_pwm_15_8 <= frame_dat;
                    ADDR_DUTY: begin
                        pend_val_q  <= frame_dat;
                        pend_flag_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: protocol-level model checked every cycle plus literal expectations.
module tb_spi_reg_ctrl;

    localparam int S    = 2;
    localparam int NREG = 5;
    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_copi = 1'b0;
    logic       spi_ncs = 1'b1;
    logic       pwm_period_wrap = 1'b0;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe, frame_err;

    always #5 clk = ~clk;

    spi_reg_ctrl #(.SYNC_STAGES(S), .NUM_REGS(NREG)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_copi(spi_copi), .spi_ncs(spi_ncs),
        .pwm_period_wrap(pwm_period_wrap),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle),
        .wr_strobe(wr_strobe), .frame_err(frame_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- protocol-level model ----------------
    logic [7:0]  m_reg [NREG];
    logic [7:0]  m_pend;
    logic        m_pflag, m_strobe, m_err;
    logic        in_frame, armed, started = 1'b0;
    logic [15:0] m_bits, c_bits;
    int          m_n, c_n, cd, rst_age;
    logic        prev_ncs = 1'b1, prev_sclk = 1'b0;

    always @(posedge clk) begin
        m_strobe = 1'b0;
        m_err    = 1'b0;
        if (rst) begin
            for (int i = 0; i < NREG; i++) m_reg[i] = 8'h00;
            m_pend = 8'h00; m_pflag = 1'b0;
            in_frame = 1'b0; armed = 1'b0; cd = 0; rst_age = 0;
            m_bits = 16'h0; m_n = 0;
        end else begin
            rst_age++;
            if (pwm_period_wrap && m_pflag) begin
                m_reg[4] = m_pend;
                m_pflag  = 1'b0;
            end
            if (cd == 1) begin
                if (c_n != 16) m_err = 1'b1;
                else if (c_bits[15]) begin
                    if (int'(c_bits[14:8]) < NREG) begin
                        m_strobe = 1'b1;
                        if (c_bits[14:8] == 7'd4) begin
                            m_pend = c_bits[7:0]; m_pflag = 1'b1;
                        end else m_reg[c_bits[14:8]] = c_bits[7:0];
                    end else m_err = 1'b1;
                end
            end
            if (cd > 0) cd--;
            if (!spi_ncs && prev_ncs && armed) begin
                in_frame = 1'b1; m_n = 0; m_bits = 16'h0;
            end else if (in_frame && spi_ncs && !prev_ncs) begin
                in_frame = 1'b0; c_bits = m_bits; c_n = m_n; cd = S + 1;
            end else if (in_frame && !spi_ncs && spi_sclk && !prev_sclk) begin
                m_bits = {m_bits[14:0], spi_copi}; m_n++;
            end
            if (spi_ncs && rst_age > S + 2) armed = 1'b1;
        end
        prev_ncs  = spi_ncs;
        prev_sclk = spi_sclk;
        started   = 1'b1;
    end

    int n_strobe = 0;
    int n_err    = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("out_7_0",   en_reg_out_7_0,  m_reg[0]);
            chk("out_15_8",  en_reg_out_15_8, m_reg[1]);
            chk("pwm_7_0",   en_reg_pwm_7_0,  m_reg[2]);
            chk("pwm_15_8",  en_reg_pwm_15_8, m_reg[3]);
            chk("duty",      pwm_duty_cycle,  m_reg[4]);
            chk("wr_strobe", wr_strobe,       m_strobe);
            chk("frame_err", frame_err,       m_err);
            if (wr_strobe === 1'b1) n_strobe++;
            if (frame_err === 1'b1) n_err++;
        end
    end

    // ---------------- stimulus ----------------
    logic snap_strobe, snap_err;
    int   s0, e0;

    task automatic shift_bits(input logic [16:0] b, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_copi = b[i];
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
    endtask

    // Snapshots strobe/err in the cycle the commit result becomes visible.
    task automatic send(input logic [16:0] b, input int n, input bit wrap_in_commit);
        @(negedge clk);
        spi_ncs = 1'b0;
        repeat (6) @(negedge clk);
        shift_bits(b, n);
        spi_ncs = 1'b1;
        repeat (S + 1) @(posedge clk);
        @(negedge clk);
        if (wrap_in_commit) pwm_period_wrap = 1'b1;
        @(negedge clk);
        pwm_period_wrap = 1'b0;
        snap_strobe = wr_strobe;
        snap_err    = frame_err;
        repeat (S + 8) @(negedge clk);
    endtask

    task automatic wrap_pulse();
        @(negedge clk);
        pwm_period_wrap = 1'b1;
        @(negedge clk);
        pwm_period_wrap = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_out_7_0", en_reg_out_7_0, 8'h00);
        chk("rst_duty", pwm_duty_cycle, 8'h00);
        chk("rst_strobe", wr_strobe, 1'b0);

        // Write 0xFF to 0x00
        s0 = n_strobe; e0 = n_err;
        send(17'h080FF, 16, 1'b0);
        chk("w00_strobe_at_update", snap_strobe, 1'b1);
        chk("w00_value", en_reg_out_7_0, 8'hFF);
        chk("w00_one_strobe", n_strobe - s0, 1);
        chk("w00_no_err", n_err - e0, 0);

        // Remaining plain registers
        send(17'h081A5, 16, 1'b0);
        send(17'h0823C, 16, 1'b0);
        send(17'h0835A, 16, 1'b0);
        chk("w01", en_reg_out_15_8, 8'hA5);
        chk("w02", en_reg_pwm_7_0, 8'h3C);
        chk("w03", en_reg_pwm_15_8, 8'h5A);

        // Duty waits for a wrap
        send(17'h08480, 16, 1'b0);
        chk("duty_held", pwm_duty_cycle, 8'h00);
        wrap_pulse();
        chk("duty_applied", pwm_duty_cycle, 8'h80);

        // Back-to-back duty writes: last wins, second wrap is a no-op
        send(17'h08440, 16, 1'b0);
        send(17'h084C0, 16, 1'b0);
        chk("duty_b2b_held", pwm_duty_cycle, 8'h80);
        wrap_pulse();
        chk("duty_b2b_wrap1", pwm_duty_cycle, 8'hC0);
        wrap_pulse();
        chk("duty_b2b_wrap2", pwm_duty_cycle, 8'hC0);

        // Discarded frames
        s0 = n_strobe; e0 = n_err;
        send(17'h040FF, 15, 1'b0);
        chk("err_15bit", snap_err, 1'b1);
        send(17'h101FF, 17, 1'b0);
        chk("err_17bit", snap_err, 1'b1);
        send(17'h08555, 16, 1'b0);
        chk("err_addr5", snap_err, 1'b1);
        chk("err_count", n_err - e0, 3);
        chk("err_no_strobe", n_strobe - s0, 0);
        chk("err_keep_00", en_reg_out_7_0, 8'hFF);
        chk("err_keep_01", en_reg_out_15_8, 8'hA5);

        // Read frame is silent
        s0 = n_strobe; e0 = n_err;
        send(17'h00155, 16, 1'b0);
        chk("rd_no_strobe", n_strobe - s0, 0);
        chk("rd_no_err", n_err - e0, 0);
        chk("rd_keep_01", en_reg_out_15_8, 8'hA5);

        // Wrap coinciding with a duty commit
        send(17'h08411, 16, 1'b0);
        send(17'h08422, 16, 1'b1);
        chk("coinc_old_applied", pwm_duty_cycle, 8'h11);
        chk("coinc_strobe", snap_strobe, 1'b1);
        wrap_pulse();
        chk("coinc_new_pending", pwm_duty_cycle, 8'h22);

        // Reset mid-frame, then bits with ncs still low
        s0 = n_strobe; e0 = n_err;
        @(negedge clk);
        spi_ncs = 1'b0;
        repeat (6) @(negedge clk);
        shift_bits(17'h00081, 8);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        shift_bits(17'h00077, 8);
        spi_ncs = 1'b1;
        repeat (S + 10) @(negedge clk);
        chk("rstmid_no_strobe", n_strobe - s0, 0);
        chk("rstmid_no_err", n_err - e0, 0);
        chk("rstmid_out_7_0", en_reg_out_7_0, 8'h00);
        chk("rstmid_out_15_8", en_reg_out_15_8, 8'h00);
        chk("rstmid_duty", pwm_duty_cycle, 8'h00);

        // Recovery after the abandoned frame
        send(17'h08012, 16, 1'b0);
        chk("recover_w00", en_reg_out_7_0, 8'h12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
